// File: rtl/vertex_apply_single_pkg.sv
// Shared types and constants for the vertex_apply_single slice.
package vertex_apply_single_pkg;

    localparam int DEF_V_ID_WIDTH      = 20;
    localparam int DEF_V_VALUE_WIDTH   = 32;
    localparam int DEF_ITERATION_WIDTH = 6;
    localparam int DEF_CORE_NUM_WIDTH  = 5;
    localparam int DEF_LOCAL_AWIDTH    = DEF_V_ID_WIDTH - DEF_CORE_NUM_WIDTH;

    // Infinity is the all-ones value; replicate this bit to any value width.
    localparam logic V_INF_BIT = 1'b1;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_APPLY,
        ST_DRAIN,
        ST_SCAN,
        ST_END
    } state_t;

endpackage

// File: rtl/vertex_apply_single_if.sv
// Scheduler-side and frontier-side signals of one apply core.
// VERTEX_APPLY_STATS_EN adds the three statistics counters.
interface vertex_apply_single_if
    import vertex_apply_single_pkg::*;
#(
    parameter int V_ID_WIDTH      = DEF_V_ID_WIDTH,
    parameter int V_VALUE_WIDTH   = DEF_V_VALUE_WIDTH,
    parameter int ITERATION_WIDTH = DEF_ITERATION_WIDTH
);
    logic [V_ID_WIDTH-1:0]      update_v_id;
    logic [V_VALUE_WIDTH-1:0]   update_v_value;
    logic                       update_v_valid;
    logic                       iteration_end;
    logic                       iteration_end_valid;
    logic [ITERATION_WIDTH-1:0] iteration_id;
    logic                       next_stage_full;
    logic                       stage_full;
    logic [V_ID_WIDTH-1:0]      active_v_id;
    logic [V_VALUE_WIDTH-1:0]   active_v_value;
    logic                       active_v_valid;
    logic                       iteration_done;
    logic [ITERATION_WIDTH-1:0] iteration_done_id;
    logic                       frontier_empty;
    logic                       init_done;
`ifdef VERTEX_APPLY_STATS_EN
    logic [31:0]                stat_updates;
    logic [31:0]                stat_improved;
    logic [31:0]                stat_dropped;

    modport master (
        output update_v_id, update_v_value, update_v_valid,
        output iteration_end, iteration_end_valid, iteration_id, next_stage_full,
        input  stage_full, active_v_id, active_v_value, active_v_valid,
        input  iteration_done, iteration_done_id, frontier_empty, init_done,
        input  stat_updates, stat_improved, stat_dropped
    );
    modport slave (
        input  update_v_id, update_v_value, update_v_valid,
        input  iteration_end, iteration_end_valid, iteration_id, next_stage_full,
        output stage_full, active_v_id, active_v_value, active_v_valid,
        output iteration_done, iteration_done_id, frontier_empty, init_done,
        output stat_updates, stat_improved, stat_dropped
    );
`else
    modport master (
        output update_v_id, update_v_value, update_v_valid,
        output iteration_end, iteration_end_valid, iteration_id, next_stage_full,
        input  stage_full, active_v_id, active_v_value, active_v_valid,
        input  iteration_done, iteration_done_id, frontier_empty, init_done
    );
    modport slave (
        input  update_v_id, update_v_value, update_v_valid,
        input  iteration_end, iteration_end_valid, iteration_id, next_stage_full,
        output stage_full, active_v_id, active_v_value, active_v_valid,
        output iteration_done, iteration_done_id, frontier_empty, init_done
    );
`endif
endinterface

// File: rtl/vertex_apply_single_apply_value_ram.sv
// Simple dual-port vertex value RAM: synchronous, read-first.
module apply_value_ram #(
    parameter int AWIDTH = 15,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);
    logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];

    // Write port and registered read; a same-edge write is not visible on rdata.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/vertex_apply_single.sv
// Per-core apply stage: min-reduces scheduler updates into the local value RAM,
// tracks improved vertices in a bitmap and streams the next frontier at iteration end.
// VERTEX_APPLY_STATS_EN adds saturating update/improved/dropped counters.
module vertex_apply_single
    import vertex_apply_single_pkg::*;
#(
    parameter int V_ID_WIDTH      = DEF_V_ID_WIDTH,
    parameter int V_VALUE_WIDTH   = DEF_V_VALUE_WIDTH,
    parameter int ITERATION_WIDTH = DEF_ITERATION_WIDTH,
    parameter int CORE_ID         = 0,
    parameter int CORE_NUM_WIDTH  = DEF_CORE_NUM_WIDTH,
    parameter int LOCAL_AWIDTH    = DEF_LOCAL_AWIDTH
) (
    input logic                clk,
    input logic                rst,
    vertex_apply_single_if.slave bus
);
    localparam int                      DEPTH = 1 << LOCAL_AWIDTH;
    localparam logic [LOCAL_AWIDTH-1:0] LAST  = '1;

    state_t                     state, state_nx;
    logic [LOCAL_AWIDTH-1:0]    ptr, ptr_d;
    logic                       scan_pend, scan_bit, scan_all, scan_emitted;
    logic [ITERATION_WIDTH-1:0] iter_q;
    logic                       stage_full_q, init_done_q;
    logic                       s1_valid;
    logic [LOCAL_AWIDTH-1:0]    s1_addr;
    logic [V_VALUE_WIDTH-1:0]   s1_val;
    logic                       fwd_we;
    logic [LOCAL_AWIDTH-1:0]    fwd_addr;
    logic [V_VALUE_WIDTH-1:0]   fwd_data;
    logic [DEPTH-1:0]           bitmap;

    logic                       core_match, upd_accept, apply_we, scan_issue, active_valid;
    logic [LOCAL_AWIDTH-1:0]    upd_addr;
    logic [V_VALUE_WIDTH-1:0]   old_val, ram_dout, ram_wdata;
    logic                       ram_we;
    logic [LOCAL_AWIDTH-1:0]    ram_waddr, ram_raddr;

    assign core_match   = bus.update_v_id[CORE_NUM_WIDTH-1:0] == CORE_NUM_WIDTH'(CORE_ID);
    assign upd_addr     = bus.update_v_id[V_ID_WIDTH-1:CORE_NUM_WIDTH];
    assign upd_accept   = bus.update_v_valid && core_match
                          && (state == ST_APPLY || state == ST_DRAIN);
    // The RAM read is read-first, so the write committed on the same edge as
    // this address's read is bypassed from the registered write.
    assign old_val      = (fwd_we && fwd_addr == s1_addr) ? fwd_data : ram_dout;
    assign apply_we     = s1_valid && (s1_val < old_val);
    assign scan_issue   = (state == ST_SCAN) && !bus.next_stage_full && !scan_all;
    assign active_valid = scan_pend && scan_bit;
    assign ram_raddr    = (state == ST_SCAN) ? ptr : upd_addr;

    apply_value_ram #(.AWIDTH(LOCAL_AWIDTH), .DWIDTH(V_VALUE_WIDTH)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_dout)
    );

    // Next-state selection for the INIT/APPLY/DRAIN/SCAN/END sequence.
    always_comb begin
        state_nx = state;
        case (state)
            ST_INIT:  if (ptr == LAST) state_nx = ST_APPLY;
            ST_APPLY: if (bus.iteration_end && bus.iteration_end_valid) state_nx = ST_DRAIN;
            ST_DRAIN: if (!s1_valid && !upd_accept) state_nx = ST_SCAN;
            ST_SCAN:  if (scan_pend && ptr_d == LAST) state_nx = ST_END;
            ST_END:   state_nx = ST_APPLY;
            default:  state_nx = ST_INIT;
        endcase
    end

    // RAM write port: infinity sweep during INIT, improved values otherwise.
    always_comb begin
        ram_we    = apply_we;
        ram_waddr = s1_addr;
        ram_wdata = s1_val;
        if (state == ST_INIT) begin
            ram_we    = 1'b1;
            ram_waddr = ptr;
            ram_wdata = {V_VALUE_WIDTH{V_INF_BIT}};
        end
    end

    // FSM state, sweep/scan pointer and scan bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_INIT;
            ptr          <= '0;
            ptr_d        <= '0;
            scan_pend    <= 1'b0;
            scan_bit     <= 1'b0;
            scan_all     <= 1'b0;
            scan_emitted <= 1'b0;
            iter_q       <= '0;
            stage_full_q <= 1'b1;
            init_done_q  <= 1'b0;
        end else begin
            state        <= state_nx;
            stage_full_q <= (state_nx != ST_APPLY);
            scan_pend    <= scan_issue;
            if (state == ST_INIT) begin
                ptr <= ptr + 1'b1;
                if (state_nx == ST_APPLY) init_done_q <= 1'b1;
            end
            if (state == ST_APPLY && state_nx == ST_DRAIN) iter_q <= bus.iteration_id;
            if (state == ST_DRAIN) begin
                ptr          <= '0;
                scan_all     <= 1'b0;
                scan_emitted <= 1'b0;
            end
            if (scan_issue) begin
                ptr      <= ptr + 1'b1;
                ptr_d    <= ptr;
                scan_bit <= bitmap[ptr];
                if (ptr == LAST) scan_all <= 1'b1;
            end
            if (active_valid) scan_emitted <= 1'b1;
        end
    end

    // Update pipeline: input register stage plus the last-write forwarding register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_val   <= '0;
            fwd_we   <= 1'b0;
            fwd_addr <= '0;
            fwd_data <= '0;
        end else begin
            s1_valid <= upd_accept;
            if (upd_accept) begin
                s1_addr <= upd_addr;
                s1_val  <= bus.update_v_value;
            end
            fwd_we   <= apply_we;
            fwd_addr <= s1_addr;
            fwd_data <= s1_val;
        end
    end

    // Active bitmap: cleared by the INIT sweep, set on improvement, cleared as scanned.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) bitmap[ptr] <= 1'b0;
        else if (apply_we) bitmap[s1_addr] <= 1'b1;
        else if (scan_issue) bitmap[ptr] <= 1'b0;
    end

    assign bus.stage_full        = stage_full_q;
    assign bus.init_done         = init_done_q;
    assign bus.active_v_valid    = active_valid;
    assign bus.active_v_id       = active_valid ? {ptr_d, CORE_NUM_WIDTH'(CORE_ID)} : '0;
    assign bus.active_v_value    = active_valid ? ram_dout : '0;
    assign bus.iteration_done    = (state == ST_END);
    assign bus.iteration_done_id = (state == ST_END) ? iter_q : '0;
    assign bus.frontier_empty    = (state == ST_END) && !scan_emitted;

`ifdef VERTEX_APPLY_STATS_EN
    logic [31:0] cnt_upd, cnt_imp, cnt_drop;
    logic        drop_evt;

    assign drop_evt = bus.update_v_valid && (!core_match || state == ST_INIT);

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_upd  <= '0;
            cnt_imp  <= '0;
            cnt_drop <= '0;
        end else begin
            if (upd_accept && cnt_upd != '1) cnt_upd <= cnt_upd + 1'b1;
            if (apply_we && cnt_imp != '1) cnt_imp <= cnt_imp + 1'b1;
            if (drop_evt && cnt_drop != '1) cnt_drop <= cnt_drop + 1'b1;
        end
    end

    assign bus.stat_updates  = cnt_upd;
    assign bus.stat_improved = cnt_imp;
    assign bus.stat_dropped  = cnt_drop;
`endif

endmodule

// File: tb/tb_vertex_apply_single.sv
// Self-checking bench for vertex_apply_single with a small local RAM (32 entries).
module tb_vertex_apply_single;
    localparam int VW = 10, DW = 32, ITW = 6, CID = 3, CNW = 5, AW = 5;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vertex_apply_single_if #(.V_ID_WIDTH(VW), .V_VALUE_WIDTH(DW), .ITERATION_WIDTH(ITW)) bus ();

    vertex_apply_single #(
        .V_ID_WIDTH(VW), .V_VALUE_WIDTH(DW), .ITERATION_WIDTH(ITW),
        .CORE_ID(CID), .CORE_NUM_WIDTH(CNW), .LOCAL_AWIDTH(AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: value per local address, improved flag, event counts.
    logic [DW-1:0]  m_val [DEPTH];
    bit             m_act [DEPTH];
    int             m_acc = 0, m_imp = 0, m_drop = 0;
    logic [VW-1:0]  exp_id[$], got_id[$];
    logic [DW-1:0]  exp_val[$], got_val[$];
    bit             got_done, got_empty, sf_gap, sf_after;
    logic [ITW-1:0] got_done_id;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] gid(input int a);
        return VW'((a << CNW) | CID);
    endfunction

    task automatic model_reset;
        for (int i = 0; i < DEPTH; i++) begin
            m_val[i] = '1;
            m_act[i] = 1'b0;
        end
    endtask

    task automatic drive_upd(input logic [VW-1:0] id, input logic [DW-1:0] v);
        int a;
        bus.update_v_id    = id;
        bus.update_v_value = v;
        bus.update_v_valid = 1'b1;
        a = int'(id >> CNW);
        if (int'(id % (1 << CNW)) == CID) begin
            m_acc++;
            if (v < m_val[a]) begin
                m_val[a] = v;
                m_act[a] = 1'b1;
                m_imp++;
            end
        end else begin
            m_drop++;
        end
    endtask

    task automatic send_upd(input logic [VW-1:0] id, input logic [DW-1:0] v);
        drive_upd(id, v);
        tick();
        bus.update_v_valid = 1'b0;
    endtask

    // Pulses iteration_end (optionally with a same-cycle and a skid update), builds the
    // expected frontier from the model and collects what the DUT streams out.
    task automatic run_end(input logic [ITW-1:0] iter, input bit bp,
                           input bit has_upd, input logic [VW-1:0] uid, input logic [DW-1:0] uval,
                           input bit has_skid, input logic [VW-1:0] sid, input logic [DW-1:0] sval);
        got_id.delete(); got_val.delete(); exp_id.delete(); exp_val.delete();
        bus.iteration_end       = 1'b1;
        bus.iteration_end_valid = 1'b1;
        bus.iteration_id        = iter;
        if (has_upd) drive_upd(uid, uval);
        tick();
        bus.iteration_end       = 1'b0;
        bus.iteration_end_valid = 1'b0;
        bus.update_v_valid      = 1'b0;
        if (has_skid) begin
            drive_upd(sid, sval);
            tick();
            bus.update_v_valid = 1'b0;
        end
        for (int a = 0; a < DEPTH; a++) begin
            if (m_act[a]) begin
                exp_id.push_back(gid(a));
                exp_val.push_back(m_val[a]);
                m_act[a] = 1'b0;
            end
        end
        got_done = 1'b0;
        sf_gap   = 1'b0;
        for (int c = 0; c < 600 && !got_done; c++) begin
            bus.next_stage_full = bp && (((c / 2) % 2) == 1);
            tick();
            if (bus.active_v_valid) begin
                got_id.push_back(bus.active_v_id);
                got_val.push_back(bus.active_v_value);
            end
            if (bus.iteration_done) begin
                got_done    = 1'b1;
                got_done_id = bus.iteration_done_id;
                got_empty   = bus.frontier_empty;
            end else if (!bus.stage_full) begin
                sf_gap = 1'b1;
            end
        end
        bus.next_stage_full = 1'b0;
        tick();
        sf_after = bus.stage_full;
    endtask

    task automatic test_reset;
        int  n;
        bit  bad;
        #2 rst = 1'b0;
        tick(); tick();
        checks++;
        if (bus.stage_full !== 1'b1 || bus.init_done !== 1'b0 || bus.active_v_valid !== 1'b0 ||
            bus.iteration_done !== 1'b0 || bus.frontier_empty !== 1'b0 ||
            bus.active_v_id !== '0 || bus.active_v_value !== '0 || bus.iteration_done_id !== '0) begin
            errors++;
            $display("FAIL reset_outputs: stage_full=%0b init_done=%0b valid=%0b done=%0b (want 1 0 0 0)",
                     bus.stage_full, bus.init_done, bus.active_v_valid, bus.iteration_done);
        end
        rst = 1'b1;
        n   = 0;
        bad = 1'b0;
        while (!bus.init_done && n < 200) begin
            tick();
            n++;
            if (!bus.init_done && bus.stage_full !== 1'b1) bad = 1'b1;
            if (bus.active_v_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (n != DEPTH || bus.stage_full !== 1'b0 || bad) begin
            errors++;
            $display("FAIL init_sweep: cycles=%0d stage_full=%0b glitch=%0b (want %0d 0 0)",
                     n, bus.stage_full, bad, DEPTH);
        end
    endtask

    task automatic test_single;
        drive_upd(10'h023, 32'd5); tick();
        drive_upd(10'h023, 32'd9); tick();
        bus.update_v_valid = 1'b0;
        run_end(6'd1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        checks++;
        if (got_id.size() != 1 || got_id[0] !== 10'h023 || got_val[0] !== 32'd5) begin
            errors++;
            $display("FAIL single_frontier: items=%0d first=(%0h,%0d) want 1 item (23,5)",
                     got_id.size(), got_id.size() ? got_id[0] : '0, got_val.size() ? got_val[0] : '0);
        end
        checks++;
        if (!got_done || got_done_id !== 6'd1 || got_empty !== 1'b0 || sf_gap || sf_after !== 1'b0) begin
            errors++;
            $display("FAIL single_done: done=%0b id=%0d empty=%0b gap=%0b sf_after=%0b want 1 1 0 0 0",
                     got_done, got_done_id, got_empty, sf_gap, sf_after);
        end
    endtask

    task automatic test_forwarding;
        drive_upd(gid(2), 32'd10); tick();
        drive_upd(gid(2), 32'd7);  tick();
        drive_upd(gid(2), 32'd8);  tick();
        bus.update_v_valid = 1'b0;
        run_end(6'd2, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        checks++;
        if (got_id.size() != 1 || got_id[0] !== 10'h043 || got_val[0] !== 32'd7 || got_done_id !== 6'd2) begin
            errors++;
            $display("FAIL forwarding: items=%0d value=%0d done_id=%0d want 1 item value 7 id 2",
                     got_id.size(), got_val.size() ? got_val[0] : '0, got_done_id);
        end
    endtask

    task automatic test_drop;
        send_upd(10'h024, 32'd2);
        run_end(6'd3, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        checks++;
        if (got_id.size() != 0 || !got_done || got_empty !== 1'b1) begin
            errors++;
            $display("FAIL drop_core_id: items=%0d done=%0b empty=%0b want 0 1 1",
                     got_id.size(), got_done, got_empty);
        end
`ifdef VERTEX_APPLY_STATS_EN
        checks++;
        if (bus.stat_dropped !== 32'd1) begin
            errors++;
            $display("FAIL stat_dropped_first: got %0d want 1", bus.stat_dropped);
        end
`endif
    endtask

    task automatic test_backpressure;
        int a0, a1, a2;
        a0 = $urandom_range(10, 16);
        a1 = $urandom_range(17, 23);
        a2 = $urandom_range(24, 31);
        send_upd(gid(a2), $urandom_range(1, 1000));
        send_upd(gid(a0), $urandom_range(1, 1000));
        send_upd(gid(a1), $urandom_range(1, 1000));
        run_end(6'd4, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        checks++;
        if (got_id.size() != 3 || exp_id.size() != 3) begin
            errors++;
            $display("FAIL bp_count: got %0d items want 3", got_id.size());
        end
        for (int i = 0; i < got_id.size() && i < exp_id.size(); i++) begin
            checks++;
            if (got_id[i] !== exp_id[i] || got_val[i] !== exp_val[i]) begin
                errors++;
                $display("FAIL bp_item%0d: got (%0h,%0d) want (%0h,%0d)",
                         i, got_id[i], got_val[i], exp_id[i], exp_val[i]);
            end
        end
        checks++;
        if (!got_done || got_done_id !== 6'd4 || got_empty !== 1'b0) begin
            errors++;
            $display("FAIL bp_done: done=%0b id=%0d empty=%0b want 1 4 0", got_done, got_done_id, got_empty);
        end
        run_end(6'd5, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        checks++;
        if (got_id.size() != 0 || !got_done || got_empty !== 1'b1 || got_done_id !== 6'd5) begin
            errors++;
            $display("FAIL converged_scan: items=%0d done=%0b empty=%0b id=%0d want 0 1 1 5",
                     got_id.size(), got_done, got_empty, got_done_id);
        end
    endtask

    function automatic logic [VW-1:0] rand_id;
        logic [CNW-1:0] c;
        c = CNW'(CID);
        if ($urandom_range(0, 3) == 0) begin
            c = CNW'($urandom_range(0, (1 << CNW) - 1));
            if (c == CNW'(CID)) c = c + 1'b1;
        end
        return {AW'($urandom_range(0, DEPTH - 1)), c};
    endfunction

    task automatic test_random;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 24; k++) begin
                drive_upd(rand_id(), $urandom_range(0, 60));
                tick();
                bus.update_v_valid = 1'b0;
                if ($urandom_range(0, 1) == 1) tick();
            end
            run_end(ITW'(10 + r), r[0], 1'b1, rand_id(), $urandom_range(0, 60),
                    1'b1, rand_id(), $urandom_range(0, 60));
            checks++;
            if (got_id.size() != exp_id.size()) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d items want %0d", r, got_id.size(), exp_id.size());
            end
            for (int i = 0; i < got_id.size() && i < exp_id.size(); i++) begin
                checks++;
                if (got_id[i] !== exp_id[i] || got_val[i] !== exp_val[i]) begin
                    errors++;
                    $display("FAIL rand%0d_item%0d: got (%0h,%0d) want (%0h,%0d)",
                             r, i, got_id[i], got_val[i], exp_id[i], exp_val[i]);
                end
            end
            checks++;
            if (!got_done || got_done_id !== ITW'(10 + r) || got_empty !== (exp_id.size() == 0)) begin
                errors++;
                $display("FAIL rand%0d_done: done=%0b id=%0d empty=%0b want 1 %0d %0b",
                         r, got_done, got_done_id, got_empty, 10 + r, exp_id.size() == 0);
            end
        end
`ifdef VERTEX_APPLY_STATS_EN
        checks++;
        if (bus.stat_updates !== 32'(m_acc) || bus.stat_improved !== 32'(m_imp) ||
            bus.stat_dropped !== 32'(m_drop)) begin
            errors++;
            $display("FAIL stats: got upd=%0d imp=%0d drop=%0d want %0d %0d %0d",
                     bus.stat_updates, bus.stat_improved, bus.stat_dropped, m_acc, m_imp, m_drop);
        end
`endif
    endtask

    task automatic test_reset_mid_scan;
        int n;
        send_upd(gid(1), 32'd0);
        send_upd(gid(30), 32'd0);
        bus.iteration_end       = 1'b1;
        bus.iteration_end_valid = 1'b1;
        bus.iteration_id        = 6'd20;
        tick();
        bus.iteration_end       = 1'b0;
        bus.iteration_end_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.active_v_valid !== 1'b0 || bus.active_v_id !== '0 || bus.active_v_value !== '0 ||
            bus.iteration_done !== 1'b0 || bus.init_done !== 1'b0 || bus.stage_full !== 1'b1) begin
            errors++;
            $display("FAIL mid_scan_reset: valid=%0b done=%0b init_done=%0b stage_full=%0b want 0 0 0 1",
                     bus.active_v_valid, bus.iteration_done, bus.init_done, bus.stage_full);
        end
        tick(); tick();
        rst = 1'b1;
        model_reset();
        n = 0;
        while (!bus.init_done && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL reinit_cycles: got %0d want %0d", n, DEPTH);
        end
        run_end(6'd21, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        checks++;
        if (got_id.size() != 0 || got_empty !== 1'b1 || got_done_id !== 6'd21) begin
            errors++;
            $display("FAIL bitmap_cleared: items=%0d empty=%0b id=%0d want 0 1 21",
                     got_id.size(), got_empty, got_done_id);
        end
        send_upd(gid(1), 32'd100);
        run_end(6'd22, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        checks++;
        if (got_id.size() != 1 || got_id[0] !== 10'h023 || got_val[0] !== 32'd100) begin
            errors++;
            $display("FAIL ram_reinit: items=%0d first value=%0d want 1 item (23,100)",
                     got_id.size(), got_val.size() ? got_val[0] : '0);
        end
    endtask

    initial begin
        bus.update_v_id         = '0;
        bus.update_v_value      = '0;
        bus.update_v_valid      = 1'b0;
        bus.iteration_end       = 1'b0;
        bus.iteration_end_valid = 1'b0;
        bus.iteration_id        = '0;
        bus.next_stage_full     = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_forwarding();
        test_drop();
        test_backpressure();
        test_random();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vertex_apply_single.md
Name: vertex_apply_single

Overview:
- Per-core apply stage directly downstream of the scheduler; one instance per core.
- Consumes the scheduler's update_v_id/update_v_value/update_v_valid and iteration_end/iteration_end_valid/iteration_id.
- Min-reduces each update into a local vertex-value RAM and marks improved vertices in an active bitmap.
- At iteration end, scans the bitmap and streams the next frontier (id, value) to the front-end active-vertex generator.

Parameters:
- V_ID_WIDTH, 20, global vertex id width.
- V_VALUE_WIDTH, 32, vertex value width.
- ITERATION_WIDTH, 6, iteration counter width.
- CORE_ID, 0, index of this core.
- CORE_NUM_WIDTH, 5, log2 of core count; local address = update_v_id[V_ID_WIDTH-1:CORE_NUM_WIDTH].
- LOCAL_AWIDTH, 15, local RAM address width; must equal V_ID_WIDTH-CORE_NUM_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- update_v_id  in  V_ID_WIDTH  global id of update.
- update_v_value  in  V_VALUE_WIDTH  candidate value.
- update_v_valid  in  1  update qualifier.
- iteration_end  in  1  scheduler end flag.
- iteration_end_valid  in  1  qualifies iteration_end.
- iteration_id  in  ITERATION_WIDTH  current iteration.
- next_stage_full  in  1  frontier consumer backpressure.
- stage_full  out  1  registered; to scheduler next_stage_full.
- active_v_id  out  V_ID_WIDTH  next-frontier vertex id.
- active_v_value  out  V_VALUE_WIDTH  its value.
- active_v_valid  out  1  frontier qualifier.
- iteration_done  out  1  one-cycle pulse at end of scan.
- iteration_done_id  out  ITERATION_WIDTH  iteration just finished.
- frontier_empty  out  1  valid with iteration_done; 1 = no vertex emitted (converged).
- init_done  out  1  high once the INIT sweep completes.

Behaviour:
- Reset (rst low, async): every output 0 except stage_full=1; FSM enters INIT; ptr=0.
- INIT: writes all-ones (infinity) to value RAM[ptr] and clears bitmap[ptr], one address per cycle. After 2^LOCAL_AWIDTH cycles: init_done<=1, stage_full<=0, go to APPLY.
- APPLY: 2-stage pipeline, one update per cycle, no stalls.
  - S1 registers addr/value and issues the sync RAM read.
  - S2: old = forwarded value if S2-previous wrote the same addr, else RAM dout.
  - If cand < old (unsigned): write cand and set the bitmap bit. Equal or greater: no write.
- Core-id check: updates with update_v_id[CORE_NUM_WIDTH-1:0] != CORE_ID are dropped.
- stage_full skid: stage_full is registered, so the scheduler may deliver one update in the cycle after it rises. That update is accepted in every state except INIT, where it is discarded.
- Iteration end:
  - iteration_end && iteration_end_valid in APPLY: latch iteration_id, stage_full<=1, go to DRAIN.
  - DRAIN: wait until S1/S2 are empty (max 2 cycles, including the skid update), then go to SCAN with ptr=0.
- SCAN:
  - Each cycle with !next_stage_full: read value RAM and bitmap at ptr, ptr++.
  - One cycle later, if the bit was set: active_v_id={ptr_d, CORE_ID}, active_v_value=RAM dout, active_v_valid=1; clear the bit.
  - next_stage_full high: ptr holds; the one in-flight output still completes.
- END (after the last address's output slot): iteration_done=1 for one cycle, iteration_done_id=latched id, frontier_empty=!(any emission this scan). Then stage_full<=0 and return to APPLY.
- Simultaneous update_v_valid and iteration_end: the update is applied, then DRAIN.
- iteration_end outside APPLY: ignored.
- Reset mid-operation: abort immediately, restart INIT; RAM contents are reinitialised.

Optional Feature:
- VERTEX_APPLY_STATS_EN defined adds three 32-bit saturating output counters, each cleared by reset:
  - stat_updates: accepted updates.
  - stat_improved: RAM writes in APPLY.
  - stat_dropped: core-id mismatches plus updates discarded in INIT.
- Undefined: no counter ports and no counter logic.

Decomposition:
- Package: FSM state encoding (INIT, APPLY, DRAIN, SCAN, END), the infinity constant {V_VALUE_WIDTH{1'b1}}, and the default widths.
- One sub-module, apply_value_ram: simple dual-port, sync read, read-first, depth 2^LOCAL_AWIDTH.
- Bitmap and FSM stay in the top.

Test Plan:
- Reset release -> stage_full=1 for 2^LOCAL_AWIDTH cycles; then init_done=1 and stage_full=0; no active_v_valid.
- CORE_ID=3: updates (id=0x23, 5) then (0x23, 9) -> RAM[1]=5, single bitmap bit set; end -> exactly one frontier item (0x23, 5), frontier_empty=0.
- Back-to-back same addr, values 10, 7, 8 on consecutive cycles -> final value 7 (forwarding exercised).
- update id=0x24 at CORE_ID=3 -> dropped; RAM unchanged; stat_dropped=1 when VERTEX_APPLY_STATS_EN.
- End with 3 active vertices, next_stage_full toggling every 2 cycles -> all 3 emitted once, in address order; iteration_done_id matches; a following scan emits nothing and reports frontier_empty=1.
- rst low mid-SCAN -> outputs zero at once; INIT reruns; bitmap cleared.
